// File: rtl/cnn_pool_pkg.sv
// Shared definitions for the streaming pool / unpool blocks of the CNN datapath.
package cnn_pool_pkg;

    localparam int POOL_K_DEFAULT = 2;
    localparam int DATA_W_DEFAULT = 32;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } pool_state_e;

    function automatic int win_size(input int k);
        return k * k;
    endfunction

endpackage

// File: rtl/maxunpool_stream_if.sv
// Pooled-word input stream plus expanded-window output stream of maxunpool_stream.
interface maxunpool_stream_if
    import cnn_pool_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int IDX_W  = 2
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [IDX_W-1:0]  in_idx;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]  out_pos;
    logic              out_last;
    logic              idx_err;

    modport slave (
        input  in_valid, in_data, in_idx, out_ready,
        output in_ready, out_valid, out_data, out_pos, out_last, idx_err
    );

    modport master (
        output in_valid, in_data, in_idx, out_ready,
        input  in_ready, out_valid, out_data, out_pos, out_last, idx_err
    );
endinterface

// File: rtl/window_beat_counter.sv
// Beat counter over an N-position window with a registered last-beat flag.
module window_beat_counter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         advance,
    output logic [W-1:0] cnt,
    output logic         last
);
    localparam logic [W-1:0] LAST_V = W'(N - 1);

    logic [W-1:0] cnt_inc;
    assign cnt_inc = cnt + W'(1);

    // clear wins over advance: a last-beat handshake restarts the window at 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            last <= 1'b0;
        end else if (clear) begin
            cnt  <= '0;
            last <= (LAST_V == '0);
        end else if (advance) begin
            cnt  <= cnt_inc;
            last <= (cnt_inc == LAST_V);
        end
    end
endmodule

// File: rtl/maxunpool_stream.sv
// Max-unpooling expander: one pooled word + argmax index in, K*K row-major beats out,
// value at the argmax position and zero elsewhere.
module maxunpool_stream
    import cnn_pool_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int POOL_K = POOL_K_DEFAULT,
    parameter int IDX_W  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    maxunpool_stream_if.slave  s
);
    localparam int              N   = win_size(POOL_K);
    localparam logic [IDX_W:0]  N_V = (IDX_W + 1)'(N);

    pool_state_e       state, state_nxt;
    logic              in_ready_c;
    logic              in_fire, out_fire, last;
    logic [IDX_W-1:0]  cnt, cnt_inc, held_idx;
    logic [DATA_W-1:0] held_data, out_data_q;
    logic              idx_err_q;

    assign in_fire  = s.in_valid && s.in_ready;
    assign out_fire = s.out_valid && s.out_ready;
    assign cnt_inc  = cnt + IDX_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Only combinational ready path: idle, or the last beat is leaving this cycle
    always_comb begin
        state_nxt  = state;
        in_ready_c = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (s.in_valid) state_nxt = EMIT;
            end
            EMIT: begin
                if (out_fire && last) begin
                    in_ready_c = 1'b1;
                    if (!s.in_valid) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign s.in_ready  = in_ready_c && rst_n;
    assign s.out_valid = (state == EMIT);

    window_beat_counter #(.N(N), .W(IDX_W)) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (in_fire || (out_fire && last)),
        .advance (out_fire),
        .cnt     (cnt),
        .last    (last)
    );

    // out_data is precomputed for the beat that becomes current next cycle;
    // an out-of-range held_idx never matches, so that window is all zeros
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_data  <= '0;
            held_idx   <= '0;
            out_data_q <= '0;
            idx_err_q  <= 1'b0;
        end else begin
            idx_err_q <= in_fire && ({1'b0, s.in_idx} >= N_V);
            if (in_fire) begin
                held_data  <= s.in_data;
                held_idx   <= s.in_idx;
                out_data_q <= (s.in_idx == '0) ? s.in_data : '0;
            end else if (out_fire) begin
                out_data_q <= (!last && cnt_inc == held_idx) ? held_data : '0;
            end
        end
    end

    assign s.out_data = out_data_q;
    assign s.out_pos  = cnt;
    assign s.out_last = last;
    assign s.idx_err  = idx_err_q;
endmodule
